// File: rtl/ww_pkg.sv
// Shared definitions for the ww test-storage block: word/address widths,
// host_sel encoding and the access FSM state type.
package ww_pkg;

    localparam int WORD_W    = 16;
    localparam int TS_ADDR_W = 5;
    localparam int HS_SEL_W  = 6;

    // host_sel map: 0-31 TSR n, 32+i FFR i preset, 40+i FFR i address switch
    localparam logic [HS_SEL_W-1:0] HS_TSR       = 6'd0;
    localparam logic [HS_SEL_W-1:0] HS_FF_PRESET = 6'd32;
    localparam logic [HS_SEL_W-1:0] HS_FF_ADDR   = 6'd40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/ww_ff_reg.sv
// One flip-flop register: live value, panel preset and address switch.
// The match output tells the top whether the latched access address selects it.
module ww_ff_reg
    import ww_pkg::*;
#(
    parameter int                   DATA_W   = 16,
    parameter int                   AW       = 5,
    parameter logic [AW-1:0]        RST_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              storage_reset,
    input  logic              preset_load,
    input  logic              addr_load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     match_addr,
    output logic              match,
    output logic [DATA_W-1:0] rd_value
);

    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] preset;
    logic [AW-1:0]     addr_sw;

    // Register state; storage_reset reloads from the old preset and wins over a processor write
    always_ff @(posedge clk) begin
        if (reset) begin
            value   <= '0;
            preset  <= '0;
            addr_sw <= RST_ADDR;
        end else begin
            if (preset_load) preset <= load_data;
            if (addr_load)   addr_sw <= load_data[AW-1:0];
            if (storage_reset) begin
                value <= preset;
            end else if (wr_en) begin
                value <= wr_data;
            end
        end
    end

    assign match    = (addr_sw == match_addr);
    // A read completing on a reload edge returns the reloaded contents
    assign rd_value = storage_reset ? preset : value;

endmodule

// File: rtl/ww_test_storage.sv
// Test-storage responder: 32 toggle-switch registers with N_FF flip-flop
// registers overlaid at switch-selected addresses, served through a
// fixed-latency request/ack access FSM.
//
// Handshake: the processor raises req and holds it (with we/addr/wdata valid)
// until it sees ack. The request is accepted in IDLE on the first edge req=1;
// the attributes are latched there and ignored afterwards. ack is a one-cycle
// strobe ACCESS_CYCLES+1 cycles after acceptance; rdata is valid only while
// ack=1 and is 0 otherwise.
module ww_test_storage
    import ww_pkg::*;
#(
    parameter int WORD_W        = ww_pkg::WORD_W,
    parameter int ADDR_W        = ww_pkg::TS_ADDR_W,
    parameter int N_FF          = 5,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    input  logic              host_we,
    input  logic [5:0]        host_sel,
    input  logic [WORD_W-1:0] host_wdata,
    input  logic              storage_reset,
    output logic [1:0]        fsm_state
);

    localparam int CNT_W  = $clog2(ACCESS_CYCLES + 1);
    localparam int N_TSR  = 2 ** ADDR_W;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [WORD_W-1:0]   lat_wdata;
    logic                done;

    logic [WORD_W-1:0]   tsr [N_TSR];
    logic                host_tsr;
    logic [WORD_W-1:0]   tsr_rd;

    logic [N_FF-1:0]     ff_match;
    logic [N_FF-1:0]     ff_hit;
    logic [WORD_W-1:0]   ff_rd [N_FF];
    logic                hit_ff;
    logic [WORD_W-1:0]   hit_data;

    assign fsm_state = state;
    assign done      = (cnt == CNT_W'(ACCESS_CYCLES - 1));
    assign host_tsr  = host_we && (host_sel < HS_FF_PRESET);

    // TSR read path sees a host load landing on the same edge
    assign tsr_rd = (host_tsr && (host_sel[ADDR_W-1:0] == lat_addr))
                  ? host_wdata : tsr[lat_addr];

    genvar gi;
    generate
        for (gi = 0; gi < N_FF; gi++) begin : g_ff
            ww_ff_reg #(
                .DATA_W   (WORD_W),
                .AW       (ADDR_W),
                .RST_ADDR (ADDR_W'(gi + 2))
            ) u_ff (
                .clk           (clk),
                .reset         (reset),
                .storage_reset (storage_reset),
                .preset_load   (host_we && (host_sel == HS_FF_PRESET + 6'(gi))),
                .addr_load     (host_we && (host_sel == HS_FF_ADDR + 6'(gi))),
                .load_data     (host_wdata),
                .wr_en         ((state == BUSY) && done && lat_we && ff_hit[gi]),
                .wr_data       (lat_wdata),
                .match_addr    (lat_addr),
                .match         (ff_match[gi]),
                .rd_value      (ff_rd[gi])
            );
        end
    endgenerate

    // Priority select: lowest-index matching FFR wins, otherwise the TSR
    always_comb begin
        ff_hit   = '0;
        hit_ff   = 1'b0;
        hit_data = tsr_rd;
        for (int i = 0; i < N_FF; i++) begin
            if (ff_match[i] && !hit_ff) begin
                ff_hit[i] = 1'b1;
                hit_ff    = 1'b1;
                hit_data  = ff_rd[i];
            end
        end
    end

    // TSR array: loaded only from the host port, read-only to the processor
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TSR; i++) tsr[i] <= '0;
        end else if (host_tsr) begin
            tsr[host_sel[ADDR_W-1:0]] <= host_wdata;
        end
    end

    // Access FSM with registered ack/rdata
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            rdata     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack   <= 1'b0;
                    rdata <= '0;
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        cnt       <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (done) begin
                        ack   <= 1'b1;
                        rdata <= lat_we ? '0 : hit_data;
                        state <= ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: begin
                    ack   <= 1'b0;
                    rdata <= '0;
                    state <= IDLE;
                end
                default: begin
                    ack   <= 1'b0;
                    rdata <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ww_test_storage.sv
// Bench for ww_test_storage: reference model of TSR/FFR contents, expected
// read data queued when a read is issued and popped when ack arrives.
module tb_ww_test_storage;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ack;
    logic        host_we;
    logic [5:0]  host_sel;
    logic [15:0] host_wdata;
    logic        storage_reset;
    logic [1:0]  fsm_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    // reference model
    logic [15:0] m_tsr [32];
    logic [15:0] m_val [5];
    logic [15:0] m_pre [5];
    logic [4:0]  m_adr [5];

    ww_test_storage dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .we            (we),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .ack           (ack),
        .host_we       (host_we),
        .host_sel      (host_sel),
        .host_wdata    (host_wdata),
        .storage_reset (storage_reset),
        .fsm_state     (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_tsr[i] = '0;
        for (int i = 0; i < 5; i++) begin
            m_val[i] = '0;
            m_pre[i] = '0;
            m_adr[i] = 5'(i + 2);
        end
    endtask

    function automatic logic [15:0] lookup(input logic [4:0] a);
        for (int i = 0; i < 5; i++) if (m_adr[i] == a) return m_val[i];
        return m_tsr[a];
    endfunction

    function automatic int ff_index(input logic [4:0] a);
        for (int i = 0; i < 5; i++) if (m_adr[i] == a) return i;
        return -1;
    endfunction

    // host/panel load: one strobe cycle
    task automatic host_load(input logic [5:0] sel, input logic [15:0] val);
        @(negedge clk);
        host_we = 1'b1; host_sel = sel; host_wdata = val;
        @(negedge clk);
        host_we = 1'b0;
        if (sel < 6'd32)      m_tsr[sel[4:0]] = val;
        else if (sel < 6'd40) m_pre[sel - 6'd32] = val;
        else                  m_adr[sel - 6'd40] = val[4:0];
    endtask

    task automatic sr_pulse();
        @(negedge clk);
        storage_reset = 1'b1;
        @(negedge clk);
        storage_reset = 1'b0;
        for (int i = 0; i < 5; i++) m_val[i] = m_pre[i];
    endtask

    // processor access; sr_edge>0 asserts storage_reset on that edge after req
    task automatic do_access(input logic w, input logic [4:0] a, input logic [15:0] d,
                             input int sr_edge);
        int lat;
        bit got;
        int idx;
        if (sr_edge != 0) for (int i = 0; i < 5; i++) m_val[i] = m_pre[i];
        idx = ff_index(a);
        if (!w) exp_q.push_back(lookup(a));
        else if (idx >= 0 && sr_edge == 0) m_val[idx] = d;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                we = ~w; addr = ~a; wdata = ~d;
            end
            storage_reset = (sr_edge != 0 && lat == sr_edge - 1);
            if (ack) got = 1'b1;
        end
        req = 1'b0;
        storage_reset = 1'b0;
        check("ack_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'd5);
        if (got && !w) check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
        @(negedge clk);
        check("ack_pulse", 32'(ack), 32'd0);
        check("rdata_idle", 32'(rdata), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        host_we = 1'b0; host_sel = '0; host_wdata = '0; storage_reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);

        // TSR load and read
        host_load(6'd21, 16'o103744);
        do_access(1'b0, 5'o25, '0, 0);

        // FFR3 preset, reload, read overlays TSR 'o05
        host_load(6'd5, 16'o012345);
        host_load(6'd35, 16'o177777);
        sr_pulse();
        do_access(1'b0, 5'o05, '0, 0);

        // processor write to FFR2, and ignored write to a TSR
        do_access(1'b1, 5'o04, 16'o000123, 0);
        do_access(1'b0, 5'o04, '0, 0);
        do_access(1'b1, 5'o25, 16'o000777, 0);
        do_access(1'b0, 5'o25, '0, 0);

        // two FFRs at the same address: lowest index wins
        do_access(1'b1, 5'o03, 16'o000001, 0);
        do_access(1'b1, 5'o06, 16'o000004, 0);
        host_load(6'd8, 16'o007070);
        host_load(6'd41, 16'o10);
        host_load(6'd44, 16'o10);
        do_access(1'b0, 5'o10, '0, 0);

        // write to FFR0 colliding with storage_reset: preset wins
        host_load(6'd32, 16'o070707);
        do_access(1'b1, 5'o02, 16'o000111, 5);
        do_access(1'b0, 5'o02, '0, 0);
        do_access(1'b0, 5'o10, '0, 0);

        // read landing on a reload edge returns the reloaded value
        host_load(6'd35, 16'o004444);
        do_access(1'b0, 5'o05, '0, 5);

        // random TSR loads and reads
        for (int k = 0; k < 8; k++) begin
            logic [4:0] ra;
            ra = 5'($urandom_range(0, 31));
            host_load({1'b0, ra}, 16'($urandom_range(0, 65535)));
            do_access(1'b0, ra, '0, 0);
        end

        // reset during BUSY aborts the access
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 5'o02; wdata = 16'o000555;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("busy_state", 32'(fsm_state), 32'd1);
        reset = 1'b1; req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            check("abort_ack", 32'(ack), 32'd0);
            @(negedge clk);
        end
        check("abort_state", 32'(fsm_state), 32'd0);
        check("abort_rdata", 32'(rdata), 32'd0);
        do_access(1'b0, 5'o25, '0, 0);
        do_access(1'b0, 5'o02, '0, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
